// File: rtl/tqvp_rejunity_vga_copper.sv
// rtl/tqvp_rejunity_vga_copper.sv - per-scanline colour sequencer (copper list) for the VGA peripheral
module tqvp_rejunity_vga_copper #(
  parameter int ENTRIES = 8,
  parameter int Y_W     = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [4:0]     cfg_addr,
  input  logic [31:0]    cfg_wdata,
  output logic [31:0]    cfg_rdata,
  input  logic           frame_start,
  input  logic           line_start,
  input  logic [Y_W-1:0] line_y,
  output logic [5:0]     bg_color,
  output logic [5:0]     fg_color,
  output logic           busy,
  output logic           irq
);

  localparam int         PTR_W   = $clog2(ENTRIES);
  localparam logic [4:0] A_CTRL  = 5'(ENTRIES);
  localparam logic [4:0] A_BASE  = 5'(ENTRIES + 1);
  localparam logic [4:0] A_STAT  = 5'(ENTRIES + 2);
  localparam logic [4:0] LEN_MAX = 5'(ENTRIES);
  localparam logic [5:0] RST_BG  = 6'b010000;
  localparam logic [5:0] RST_FG  = 6'b001011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_APPLY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // copper list storage
  logic [Y_W-1:0] r_ent_y [ENTRIES];
  logic [5:0]     r_ent_c [ENTRIES];
  logic           r_ent_t [ENTRIES];

  logic           r_en;
  logic [4:0]     r_len;
  logic [5:0]     r_base_bg;
  logic [5:0]     r_base_fg;
  logic [4:0]     r_ptr;
  state_t         r_state;
  logic [Y_W-1:0] r_ly;
  logic           r_chk;
  logic [5:0]     r_bg;
  logic [5:0]     r_fg;
  logic           r_busy;
  logic           r_irq;

  logic             w_ent_wr;
  logic             w_ctrl_wr;
  logic             w_base_wr;
  logic [4:0]       w_len_req;
  logic [4:0]       w_len_sat;
  logic             w_en;
  logic [4:0]       w_len;
  logic [5:0]       w_base_bg;
  logic [5:0]       w_base_fg;
  logic [PTR_W-1:0] w_cur;
  logic [4:0]       w_ptr_inc;
  logic [PTR_W-1:0] w_nxt;
  logic             w_cur_hit;
  logic             w_nxt_hit;
  logic             w_last;
  state_t           w_state_nx;
  logic             w_frame;
  logic             w_apply;
  logic             w_idle_base;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_ent_wr  = cfg_we && (cfg_addr < A_CTRL);
  assign w_ctrl_wr = cfg_we && (cfg_addr == A_CTRL);
  assign w_base_wr = cfg_we && (cfg_addr == A_BASE);

  assign w_len_req = {1'b0, cfg_wdata[7:4]};
  assign w_len_sat = (w_len_req > LEN_MAX) ? LEN_MAX : w_len_req;

  // A register write in the same cycle as frame_start is honoured by the reload
  assign w_en      = w_ctrl_wr ? cfg_wdata[0] : r_en;
  assign w_len     = w_ctrl_wr ? w_len_sat : r_len;
  assign w_base_bg = w_base_wr ? cfg_wdata[5:0]  : r_base_bg;
  assign w_base_fg = w_base_wr ? cfg_wdata[13:8] : r_base_fg;

  // ptr only indexes the list while it is below length, so the low bits suffice
  assign w_cur     = r_ptr[PTR_W-1:0];
  assign w_ptr_inc = r_ptr + 5'd1;
  assign w_nxt     = w_ptr_inc[PTR_W-1:0];
  assign w_cur_hit = (r_ent_y[w_cur] <= r_ly);
  assign w_nxt_hit = (r_ent_y[w_nxt] <= r_ly);
  assign w_last    = (w_ptr_inc == r_len);

  assign w_unused  = ^{cfg_wdata[31:25], cfg_wdata[23:22], cfg_wdata[15:14]};

  // Next state and datapath actions; the entry that matches in WAIT is applied on that same edge
  always_comb begin
    w_state_nx  = r_state;
    w_frame     = 1'b0;
    w_apply     = 1'b0;
    w_idle_base = 1'b0;
    if (w_ctrl_wr && !cfg_wdata[0]) begin
      w_state_nx = S_IDLE;
    end else if (frame_start && w_en) begin
      w_frame    = 1'b1;
      w_state_nx = (w_len != 5'd0) ? S_WAIT : S_DONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ctrl_wr) w_state_nx = S_DONE;
          if (w_base_wr) w_idle_base = 1'b1;
        end
        S_WAIT:  if (r_chk && w_cur_hit) w_apply = 1'b1;
        S_APPLY: w_apply = 1'b1;
        default: ;
      endcase
      if (w_apply) begin
        if (w_last)         w_state_nx = S_DONE;
        else if (w_nxt_hit) w_state_nx = S_APPLY;
        else                w_state_nx = S_WAIT;
      end
    end
  end

  // Register file, line latch, sequencer state and colour outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ent_y[i] <= '0;
        r_ent_c[i] <= '0;
        r_ent_t[i] <= 1'b0;
      end
      r_en      <= 1'b0;
      r_len     <= '0;
      r_base_bg <= RST_BG;
      r_base_fg <= RST_FG;
      r_ptr     <= '0;
      r_state   <= S_IDLE;
      r_ly      <= '0;
      r_chk     <= 1'b0;
      r_bg      <= RST_BG;
      r_fg      <= RST_FG;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_chk <= line_start;
      if (line_start) r_ly <= line_y;

      if (w_ent_wr) begin
        r_ent_y[cfg_addr[PTR_W-1:0]] <= cfg_wdata[Y_W-1:0];
        r_ent_c[cfg_addr[PTR_W-1:0]] <= cfg_wdata[21:16];
        r_ent_t[cfg_addr[PTR_W-1:0]] <= cfg_wdata[24];
      end
      if (w_ctrl_wr) begin
        r_en  <= cfg_wdata[0];
        r_len <= w_len_sat;
      end
      if (w_base_wr) begin
        r_base_bg <= cfg_wdata[5:0];
        r_base_fg <= cfg_wdata[13:8];
      end

      r_state <= w_state_nx;
      r_busy  <= w_apply;
      r_irq   <= w_apply && w_last;

      if (w_frame) begin
        r_bg  <= w_base_bg;
        r_fg  <= w_base_fg;
        r_ptr <= '0;
      end else if (w_idle_base) begin
        r_bg <= cfg_wdata[5:0];
        r_fg <= cfg_wdata[13:8];
      end else if (w_apply) begin
        if (r_ent_t[w_cur]) r_fg <= r_ent_c[w_cur];
        else                r_bg <= r_ent_c[w_cur];
        r_ptr <= w_ptr_inc;
      end
    end
  end

  // Zero-latency register read mux
  always_comb begin
    w_rdata = '0;
    if (cfg_addr < A_CTRL) begin
      w_rdata[Y_W-1:0] = r_ent_y[cfg_addr[PTR_W-1:0]];
      w_rdata[21:16]   = r_ent_c[cfg_addr[PTR_W-1:0]];
      w_rdata[24]      = r_ent_t[cfg_addr[PTR_W-1:0]];
    end else if (cfg_addr == A_CTRL) begin
      w_rdata[0]   = r_en;
      w_rdata[7:4] = r_len[3:0];
    end else if (cfg_addr == A_BASE) begin
      w_rdata[5:0]  = r_base_bg;
      w_rdata[13:8] = r_base_fg;
    end else if (cfg_addr == A_STAT) begin
      w_rdata[3:0] = r_ptr[3:0];
      w_rdata[5:4] = r_state;
    end
  end

  assign cfg_rdata = w_rdata;
  assign bg_color  = r_bg;
  assign fg_color  = r_fg;
  assign busy      = r_busy;
  assign irq       = r_irq;

endmodule

// File: tb/tb_tqvp_rejunity_vga_copper.sv
// tb/tb_tqvp_rejunity_vga_copper.sv - self-checking bench for the copper colour sequencer
module tb_tqvp_rejunity_vga_copper;

  localparam int         Y_W    = 10;
  localparam int         NLINES = 20;
  localparam int         GAP    = 12;
  localparam int         NCYC   = NLINES * GAP + 4;
  localparam logic [4:0] A_CTRL = 5'd8;
  localparam logic [4:0] A_BASE = 5'd9;
  localparam logic [4:0] A_STAT = 5'd10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_we;
  logic [4:0]     cfg_addr;
  logic [31:0]    cfg_wdata;
  logic [31:0]    cfg_rdata;
  logic           frame_start;
  logic           line_start;
  logic [Y_W-1:0] line_y;
  logic [5:0]     bg_color;
  logic [5:0]     fg_color;
  logic           busy;
  logic           irq;

  tqvp_rejunity_vga_copper #(.ENTRIES(8), .Y_W(Y_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .frame_start(frame_start), .line_start(line_start), .line_y(line_y),
    .bg_color(bg_color), .fg_color(fg_color), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  int m_y[8];
  int m_c[8];
  int m_t[8];
  int m_len;
  int m_bg;
  int m_fg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic pulse_line(input int y);
    line_start = 1'b1; line_y = Y_W'(y);
    tick();
    line_start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; line_start = 1'b1; line_y = '0;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
  endtask

  task automatic program_list();
    for (int i = 0; i < m_len; i++)
      cfg_write(5'(i), 32'((m_t[i] << 24) | (m_c[i] << 16) | m_y[i]));
    cfg_write(A_BASE, 32'((m_fg << 8) | m_bg));
    cfg_write(A_CTRL, 32'((m_len << 4) | 1));
  endtask

  // Reference: compute for each entry the cycle its colour first becomes visible,
  // then replay the frame and compare outputs against the schedule every cycle.
  task automatic run_frame(input int id);
    int vis[8];
    int napp, prev, eb, ef, ebusy, eirq;
    bit stopped;
    logic [31:0] st;
    prev = -1; napp = 0; stopped = 0;
    for (int i = 0; i < m_len; i++) begin
      if (!stopped) begin
        if (m_y[i] <= prev) begin
          vis[i] = vis[i-1] + 1;
          napp++;
        end else if (m_y[i] < NLINES) begin
          vis[i] = m_y[i] * GAP + 2;
          prev = m_y[i];
          napp++;
        end else begin
          stopped = 1;
        end
      end
    end
    for (int c = 0; c <= NCYC; c++) begin
      if (c >= 1) begin
        eb = m_bg; ef = m_fg; ebusy = 0; eirq = 0;
        for (int i = 0; i < napp; i++) begin
          if (vis[i] <= c) begin
            if (m_t[i] != 0) ef = m_c[i];
            else             eb = m_c[i];
          end
          if (vis[i] == c) begin
            ebusy = 1;
            if (i == m_len - 1) eirq = 1;
          end
        end
        check($sformatf("frame%0d_cyc%0d_bg_fg_busy_irq", id, c),
              {18'b0, bg_color, fg_color, busy, irq},
              {18'b0, 6'(eb), 6'(ef), 1'(ebusy), 1'(eirq)});
      end
      frame_start = (c == 0);
      line_start  = (c % GAP == 0) && (c / GAP < NLINES);
      line_y      = Y_W'(c / GAP);
      tick();
    end
    frame_start = 1'b0; line_start = 1'b0;
    rd(A_STAT, st);
    check($sformatf("frame%0d_status", id), st,
          32'((((napp == m_len) ? 3 : 1) << 4) | napp));
  endtask

  initial begin
    logic [31:0] rdv;

    vecs[0]  = '{1'b0, A_STAT, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, A_CTRL, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, A_BASE, 32'h0,         32'h0000_0B10};
    vecs[3]  = '{1'b0, 5'd3,   32'h0,         32'h0};
    vecs[4]  = '{1'b1, 5'd2,   32'hFFFF_FFFF, 32'h013F_03FF};
    vecs[5]  = '{1'b1, A_CTRL, 32'h0000_00F0, 32'h0000_0080};
    vecs[6]  = '{1'b1, A_CTRL, 32'h0000_0031, 32'h0000_0031};
    vecs[7]  = '{1'b0, A_STAT, 32'h0,         32'h0000_0030};
    vecs[8]  = '{1'b1, A_CTRL, 32'h0000_0000, 32'h0};
    vecs[9]  = '{1'b0, A_STAT, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 5'd11,  32'h0,         32'h0};
    vecs[11] = '{1'b1, A_STAT, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b0, 5'd31,  32'h0,         32'h0};
    vecs[13] = '{1'b1, 5'd7,   32'h0123_4567, 32'h0123_0167};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    frame_start = 1'b0; line_start = 1'b0; line_y = '0;
    tick(); tick();
    check("rst_bg", {26'b0, bg_color}, 32'h10);
    check("rst_fg", {26'b0, fg_color}, 32'h0B);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].we) cfg_write(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, rdv);
      check($sformatf("reg_vec%0d", i), rdv, vecs[i].exp);
    end

    // disabled: BASE write reaches the outputs at once, frame_start is ignored
    cfg_write(A_BASE, 32'h0000_2A15);
    check("idle_base_bg", {26'b0, bg_color}, 32'h15);
    check("idle_base_fg", {26'b0, fg_color}, 32'h2A);
    pulse_frame();
    tick();
    check("idle_frame_bg", {26'b0, bg_color}, 32'h15);
    check("idle_frame_fg", {26'b0, fg_color}, 32'h2A);
    rd(A_STAT, rdv);
    check("idle_frame_status", rdv, 32'h0);

    // frame_start while APPLY is running, then a disable while WAITing
    cfg_write(5'd0, 32'h0021_0002);
    cfg_write(5'd1, 32'h0122_0002);
    cfg_write(5'd2, 32'h0023_0007);
    cfg_write(A_CTRL, 32'h31);
    pulse_frame();
    pulse_line(1); tick(); tick(); tick();
    pulse_line(2);
    tick();
    check("apply_first_bg", {26'b0, bg_color}, 32'h21);
    check("apply_first_fg", {26'b0, fg_color}, 32'h2A);
    pulse_frame();
    check("frame_in_apply_bg", {26'b0, bg_color}, 32'h15);
    check("frame_in_apply_fg", {26'b0, fg_color}, 32'h2A);
    rd(A_STAT, rdv);
    check("frame_in_apply_status", rdv, 32'h10);
    pulse_line(1); tick(); tick(); tick();
    pulse_line(2); tick(); tick(); tick(); tick();
    check("wait_bg", {26'b0, bg_color}, 32'h21);
    check("wait_fg", {26'b0, fg_color}, 32'h22);
    rd(A_STAT, rdv);
    check("wait_status", rdv, 32'h12);
    cfg_write(A_CTRL, 32'h30);
    rd(A_STAT, rdv);
    check("disable_status", rdv, 32'h02);
    check("disable_bg", {26'b0, bg_color}, 32'h21);
    check("disable_fg", {26'b0, fg_color}, 32'h22);
    pulse_line(7); tick(); tick(); tick();
    check("disable_hold_bg", {26'b0, bg_color}, 32'h21);
    check("disable_hold_irq", {31'b0, irq}, 32'h0);

    // catch-up: entry rewritten to an already-passed line applies on the next line
    cfg_write(5'd0, 32'h0005_001E);
    cfg_write(A_CTRL, 32'h11);
    pulse_frame();
    for (int y = 1; y <= 3; y++) begin
      pulse_line(y); tick(); tick(); tick();
    end
    cfg_write(5'd0, 32'h0005_0003);
    pulse_line(4);
    check("catchup_n1_bg", {26'b0, bg_color}, 32'h15);
    tick();
    check("catchup_n2_bg", {26'b0, bg_color}, 32'h05);
    check("catchup_n2_irq", {31'b0, irq}, 32'h1);
    tick();
    check("catchup_n3_irq", {31'b0, irq}, 32'h0);

    // raster-bar list from the datasheet example
    m_len = 3; m_bg = 'h15; m_fg = 'h2A;
    m_y[0] = 5; m_c[0] = 'h30; m_t[0] = 0;
    m_y[1] = 5; m_c[1] = 'h0C; m_t[1] = 1;
    m_y[2] = 9; m_c[2] = 'h03; m_t[2] = 0;
    program_list();
    run_frame(0);

    // empty list: straight to DONE, no irq
    m_len = 0; m_bg = 'h07; m_fg = 'h38;
    program_list();
    run_frame(1);

    for (int f = 2; f < 8; f++) begin
      m_len = $urandom_range(0, 8);
      m_bg  = $urandom_range(0, 63);
      m_fg  = $urandom_range(0, 63);
      for (int i = 0; i < 8; i++) begin
        m_y[i] = $urandom_range(0, 23);
        m_c[i] = $urandom_range(0, 63);
        m_t[i] = $urandom_range(0, 1);
      end
      program_list();
      run_frame(f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tqvp_rejunity_vga_copper.md
# tqvp_rejunity_vga_copper

Per-scanline colour sequencer for the TinyQV VGA peripheral. It holds a small CPU-programmed list of (line, target, colour) entries and rewrites the background and foreground colour registers as the beam reaches each listed scanline. This produces raster bars and split-screen colour changes without CPU involvement. It sits between the register-write decode and the pixel output mux, and owns `bg_color` and `fg_color`.

## Interface
- `ENTRIES`, 8: list depth; power of two, 2..16.
- `Y_W`, 10: scanline counter width.
- `clk` input 1: pixel/system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `cfg_we` input 1: config write strobe; 32-bit write of `cfg_wdata` to `cfg_addr`.
- `cfg_addr` input 5: 0..ENTRIES-1 list entry; ENTRIES = CTRL; ENTRIES+1 = BASE; ENTRIES+2 = STATUS (read-only).
- `cfg_wdata` input 32: write data.
- `cfg_rdata` output 32: combinational read of the register at `cfg_addr`; 0 for unmapped addresses.
- `frame_start` input 1: one-cycle pulse at the start of line 0 of each frame.
- `line_start` input 1: one-cycle pulse at the start of every scanline, including line 0.
- `line_y` input Y_W: current scanline number, valid when `line_start` is high.
- `bg_color` output 6: RRGGBB background colour.
- `fg_color` output 6: RRGGBB foreground colour.
- `busy` output 1: high while in APPLY.
- `irq` output 1: one-cycle pulse when the list completes.

## Operation
- Entry format: [Y_W-1:0] = y; [21:16] = colour; [24] = target (0 = bg, 1 = fg). Other bits read as 0.
- CTRL register: [0] = enable; [7:4] = length, 0..ENTRIES; writes above ENTRIES saturate to ENTRIES.
- BASE register: [5:0] = base bg; [13:8] = base fg.
- STATUS register: [3:0] = ptr; [5:4] = state (0 IDLE, 1 WAIT, 2 APPLY, 3 DONE).
- Reset values:
  - `bg_color` = 6'b010000, `fg_color` = 6'b001011.
  - BASE = the same two colours.
  - CTRL = 0, all entries = 0, ptr = 0, state IDLE.
  - `busy` = 0, `irq` = 0.
- Line latch: when `line_start` is high, `line_y` is captured into `ly` and flag `chk` is set. `chk` clears on the next cycle.
- IDLE (enable = 0):
  - A BASE write loads both colour outputs at the same clock edge.
  - `frame_start` is ignored.
- Any state, `frame_start` with enable = 1:
  - Colours are loaded from BASE; ptr = 0.
  - State goes to WAIT if length > 0, else DONE.
  - Line 0 is latched by the coincident `line_start`.
- WAIT: if `chk` is set and entry[ptr].y <= `ly`, go to APPLY.
  - The "<=" comparison is the catch-up rule: an entry whose line was missed is applied on the next line.
- APPLY: each cycle, write entry[ptr].colour to its target and set ptr = ptr+1. Then:
  - if ptr+1 == length: go to DONE and pulse `irq`;
  - else if entry[ptr+1].y <= `ly`: stay in APPLY;
  - else: go to WAIT.
- DONE: hold until `frame_start` or disable.
- A CTRL write clearing enable goes to IDLE on the next edge. Colour outputs hold their current values; ptr holds.
- A CTRL write setting enable from IDLE goes to DONE. The list becomes active at the next `frame_start`.
- Entry writes take effect immediately, including for an entry currently pending.
- Simultaneous `frame_start` and APPLY: `frame_start` wins.
- Simultaneous `cfg_we` BASE write and `frame_start`: the new BASE value is loaded to the outputs.

## Timing
- `line_start` at cycle N → `chk`/`ly` valid in N+1. The first matching entry is applied at the N+1 edge, so the new colour is visible in cycle N+2.
- Subsequent same-line entries apply one per cycle: k entries finish at N+1+k.
- `frame_start` at cycle N → BASE colours are visible in N+1. Line-0 entries are visible from N+2.
- `irq` is high for exactly the cycle after the last entry is applied.
- `busy` equals (state == APPLY), registered.
- `cfg_rdata` has zero-cycle latency.

## Test plan
- Reset, no writes → `bg_color`=010000, `fg_color`=001011, STATUS=0, `irq`=0.
- Disabled, BASE write 0x0000_2A15 → next cycle `bg_color`=0x15, `fg_color`=0x2A; `frame_start` causes no change.
- Entries {y=5 bg=0x30, y=5 fg=0x0C, y=9 bg=0x03}, length 3, enabled, `frame_start` then `line_start` with y=0..10 → at y=5, `bg_color`=0x30 at N+2 and `fg_color`=0x0C at N+3. At y=9, `bg_color`=0x03 and `irq` pulses once. `busy` is high for 2 cycles, then 1 cycle.
- Catch-up: entry y=3 written after line 3 has passed → applied 2 cycles after the line-4 `line_start`.
- `frame_start` during APPLY, and a disable during WAIT → outputs reload from BASE with ptr=0 in the first case. In the second, state becomes IDLE and the colours hold.
- length 0 with enable → `frame_start` goes straight to DONE, `irq` never fires. A CTRL length of 15 with ENTRIES=8 reads back as 8.
